// File: rtl/fifo_status.sv
// Status/flag block for a pointer-based FIFO: derives fill, full, empty and threshold
// from the registered pointers and keeps sticky over/underflow flags plus a high-water mark.
module fifo_status #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  logic [AW:0] wptr,
  input  logic [AW:0] rptr,
  input  logic        clr_flags,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        fifo_threshold,
  output logic        fifo_overflow,
  output logic        fifo_underflow,
  output logic [AW:0] fill_level,
  output logic [AW:0] high_water
);

  localparam logic [AW:0] THRESH_L = (AW+1)'(THRESH);
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);

  // Modulo subtraction keeps fill_level correct across the wrap bit.
  assign fill_level     = wptr - rptr;
  assign fifo_empty     = (wptr == rptr);
  assign fifo_full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fifo_threshold = (fill_level >= THRESH_L);

  // Set beats clear so an attempt in the clearing cycle is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
      high_water     <= '0;
    end else begin
      if (wr && fifo_full)
        fifo_overflow <= 1'b1;
      else if (clr_flags)
        fifo_overflow <= 1'b0;

      if (rd && fifo_empty)
        fifo_underflow <= 1'b1;
      else if (clr_flags)
        fifo_underflow <= 1'b0;

      if (clr_flags || (fill_level > high_water))
        high_water <= fill_level;
    end
  end

  a_fill_range: assert property (@(posedge clk) disable iff (rst) fill_level <= DEPTH_L);
  a_full_empty: assert property (@(posedge clk) disable iff (rst) !(fifo_full && fifo_empty));

endmodule

// File: tb/tb_fifo_status.sv
// Directed self-checking bench for fifo_status with hand-computed expectations.
module tb_fifo_status;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr, rd, clr_flags;
  logic [AW:0] wptr, rptr;
  logic        fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow;
  logic [AW:0] fill_level, high_water;

  int tests = 0;
  int fails = 0;

  fifo_status #(.DEPTH(16), .AW(AW), .THRESH(12)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .wptr(wptr), .rptr(rptr),
    .clr_flags(clr_flags), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_threshold(fifo_threshold), .fifo_overflow(fifo_overflow),
    .fifo_underflow(fifo_underflow), .fill_level(fill_level), .high_water(high_water)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_flags = 1'b0;
    wptr = '0; rptr = '0;
    #12;
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_fill", 32'(fill_level), 0);
    check("rst_thr", 32'(fifo_threshold), 0);
    check("rst_hw", 32'(high_water), 0);
    check("rst_ovf", 32'(fifo_overflow), 0);
    check("rst_udf", 32'(fifo_underflow), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill sweep
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      wptr = 5'(i);
      #1;
      check($sformatf("sweep_fill_%0d", i), 32'(fill_level), 32'(i));
      check($sformatf("sweep_thr_%0d", i), 32'(fifo_threshold), (i >= 12) ? 1 : 0);
      check($sformatf("sweep_full_%0d", i), 32'(fifo_full), (i == 16) ? 1 : 0);
      check($sformatf("sweep_empty_%0d", i), 32'(fifo_empty), (i == 0) ? 1 : 0);
    end
    after_edge();
    check("sweep_hw", 32'(high_water), 16);

    // Wrapped pointers
    @(negedge clk);
    wptr = 5'd3; rptr = 5'd19;
    #1;
    check("wrap_full", 32'(fifo_full), 1);
    check("wrap_fill", 32'(fill_level), 16);
    check("wrap_notempty", 32'(fifo_empty), 0);
    @(negedge clk);
    wptr = 5'd31; rptr = 5'd31;
    #1;
    check("wrap_empty", 32'(fifo_empty), 1);
    check("wrap_notfull", 32'(fifo_full), 0);

    // Overflow sticky and set-wins-over-clear
    @(negedge clk);
    wptr = 5'd16; rptr = 5'd0; wr = 1'b1;
    #1;
    check("ovf_before", 32'(fifo_overflow), 0);
    after_edge();
    check("ovf_set", 32'(fifo_overflow), 1);
    @(negedge clk);
    wr = 1'b0;
    after_edge();
    check("ovf_hold", 32'(fifo_overflow), 1);
    @(negedge clk);
    wr = 1'b1; clr_flags = 1'b1;
    after_edge();
    check("ovf_setwins", 32'(fifo_overflow), 1);
    @(negedge clk);
    wr = 1'b0;
    after_edge();
    check("ovf_clr", 32'(fifo_overflow), 0);
    check("clr_hw_full", 32'(high_water), 16);
    @(negedge clk);
    clr_flags = 1'b0;

    // Underflow with simultaneous wr/rd while empty, then async reset
    @(negedge clk);
    wptr = 5'd5; rptr = 5'd5; wr = 1'b1; rd = 1'b1;
    after_edge();
    check("udf_set", 32'(fifo_underflow), 1);
    check("udf_no_ovf", 32'(fifo_overflow), 0);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_udf", 32'(fifo_underflow), 0);
    check("rst_async_hw", 32'(high_water), 0);
    @(negedge clk);
    rst = 1'b0;

    // High-water tracking and clear-to-current
    @(negedge clk);
    wptr = 5'd10; rptr = 5'd0;
    after_edge();
    check("hw_fill10", 32'(high_water), 10);
    @(negedge clk);
    rptr = 5'd6;
    after_edge();
    check("hw_drain4", 32'(high_water), 10);
    check("hw_fill4", 32'(fill_level), 4);
    @(negedge clk);
    clr_flags = 1'b1;
    after_edge();
    check("hw_clr", 32'(high_water), 4);
    @(negedge clk);
    clr_flags = 1'b0;
    wptr = 5'd13;
    after_edge();
    check("hw_fill7", 32'(high_water), 7);

    // Reset overrides a same-cycle overflow condition
    @(negedge clk);
    wptr = 5'd16; rptr = 5'd0; wr = 1'b1; rst = 1'b1;
    after_edge();
    check("rst_override_ovf", 32'(fifo_overflow), 0);
    check("rst_track_full", 32'(fifo_full), 1);
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    after_edge();
    check("rel_no_glitch", 32'(fifo_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
